fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controls the instruction-fetch stage. Owns the PC and issues requests to instruction memory over a req/ack handshake. Delivers fetched words into the IF/ID register (Instruccion, PC+4, valid) and applies stall, flush and branch/jump redirects from the decode stage. Sits between the hazard/branch logic and instruction memory, in place of the free-running fetch counter.

Parameters:
ADDR_W, 32, PC and memory address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_WORD, 32'h0000_0000, value driven on Instruccion when not valid

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-high
stall  in  1  hazard unit: hold IF/ID and PC
branch_taken  in  1  single-cycle redirect pulse from ID
branch_target  in  ADDR_W  target for branch_taken
jump  in  1  single-cycle redirect pulse from ID
jump_target  in  ADDR_W  target for jump
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, registered
imem_ack  in  1  memory returns imem_data this cycle; legal the same cycle as imem_req or any later cycle
imem_data  in  32  fetched word, valid with imem_ack
Instruccion  out  32  IF/ID instruction
if_pc_plus4  out  ADDR_W  IF/ID PC+4
if_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - state=IDLE, imem_req=0, imem_addr=RESET_PC
  - Instruccion=NOP_WORD, if_pc_plus4=0, if_valid=0
  - hold buffer empty, redirect_pending=0
- Reset asserted mid-transaction: immediate return to these values. Any later ack for the aborted request is ignored while in IDLE.
- States: IDLE, REQ, HOLD.
- IDLE: imem_req=0; next cycle goes to REQ. Only one IDLE cycle after reset.
- REQ: imem_req=1, imem_addr stable until imem_ack.
  - ack, no stall, no pending redirect: Instruccion<=imem_data, if_pc_plus4<=imem_addr+4, if_valid<=1, imem_addr<=imem_addr+4, stay REQ. Throughput is 1 instr/cycle with a zero-wait memory.
  - ack, stall=1: word and PC+4 go to the hold buffer; IF/ID unchanged; go to HOLD.
  - no ack: if stall=0 then if_valid<=0 (bubble); if stall=1 IF/ID holds.
- HOLD: imem_req=0; IF/ID unchanged while stall=1. On stall=0: load buffer into IF/ID with if_valid<=1, imem_addr<=buffered PC+4, go to REQ.
- Redirect priority: jump over branch_taken over sequential. Redirect overrides stall.
  - Target low 2 bits forced to 0.
  - Cycle after the redirect: if_valid=0, Instruccion=NOP_WORD; the hold buffer is discarded.
  - In REQ with no ack that cycle: set redirect_pending and latch the target; imem_addr stays stable. On the eventual ack, drop the data, set imem_addr<=latched target, clear pending. IF/ID stays invalid meanwhile.
  - With ack the same cycle, or in HOLD/IDLE: drop any data, imem_addr<=target, go to REQ.
  - Second redirect while pending: the latched target is overwritten by the newer one.
- Address arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.

Test Plan:
- Reset then zero-wait memory (ack=imem_req) -> imem_addr 0,4,8,C on consecutive cycles; Instruccion follows one cycle later with if_pc_plus4 4,8,C; if_valid=1 from cycle 3 after reset release.
- 2-cycle memory latency -> every ack is followed by one bubble (if_valid=0); imem_addr holds until ack.
- stall high 3 cycles while an ack arrives at addr 0x10 -> HOLD; IF/ID unchanged; after stall drops, Instruccion=word@0x10 and if_pc_plus4=0x14, then fetch resumes at 0x14.
- branch_taken to 0x40 while the request at 0x20 is outstanding, ack 2 cycles later -> word@0x20 never reaches IF/ID; next imem_addr=0x40; if_valid=0 until word@0x40 arrives.
- jump to 0x100 and branch_taken to 0x80 in the same cycle, with stall=1 -> jump wins; next imem_addr=0x100; IF/ID flushed.
- reset asserted while in HOLD with a redirect pending -> all outputs return to reset values the next cycle; first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// loads the IF/ID register and applies stall, flush and branch/jump redirects.
//
// state | meaning
// IDLE  | one cycle after reset, no request outstanding
// REQ   | request on imem, address held until ack
// HOLD  | fetched word parked in the hold buffer while decode stalls
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [31:0]       Instruccion,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              if_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc4_q;
  logic              valid_q;
  logic [31:0]       hold_instr_q;
  logic [ADDR_W-1:0] hold_pc4_q;
  logic              hold_valid_q;
  logic              redir_pend_q;
  logic [ADDR_W-1:0] redir_tgt_q;

  logic              redir_d;
  logic [ADDR_W-1:0] redir_tgt_d;
  logic [ADDR_W-1:0] addr_plus4_d;

  // Redirect request with jump taking priority; targets are word aligned.
  always_comb begin
    redir_d      = jump | branch_taken;
    redir_tgt_d  = (jump ? jump_target : branch_target) & ALIGN_MASK;
    addr_plus4_d = addr_q + ADDR_STEP;
  end

  // Fetch FSM with registered handshake and IF/ID outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      instr_q      <= NOP_WORD;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
      hold_instr_q <= NOP_WORD;
      hold_pc4_q   <= '0;
      hold_valid_q <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Acks seen here belong to a request aborted by reset: ignored.
          state_q <= S_REQ;
          req_q   <= 1'b1;
          if (redir_d) begin
            addr_q  <= redir_tgt_d;
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
          end
        end

        S_REQ: begin
          if (redir_d) begin
            // Redirect beats stall and any in-flight data.
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            if (imem_ack) begin
              addr_q       <= redir_tgt_d;
              redir_pend_q <= 1'b0;
            end else begin
              // Address must stay put until the memory answers; newest
              // redirect wins if several arrive before that.
              redir_pend_q <= 1'b1;
              redir_tgt_q  <= redir_tgt_d;
            end
          end else if (redir_pend_q) begin
            // Word for the abandoned address is dropped on arrival.
            if (imem_ack) begin
              addr_q       <= redir_tgt_q;
              redir_pend_q <= 1'b0;
            end
          end else if (imem_ack) begin
            if (stall) begin
              hold_instr_q <= imem_data;
              hold_pc4_q   <= addr_plus4_d;
              hold_valid_q <= 1'b1;
              state_q      <= S_HOLD;
              req_q        <= 1'b0;
            end else begin
              instr_q <= imem_data;
              pc4_q   <= addr_plus4_d;
              valid_q <= 1'b1;
              addr_q  <= addr_plus4_d;
            end
          end else if (!stall) begin
            // Memory still busy: push a bubble into decode.
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
          end
        end

        S_HOLD: begin
          if (redir_d) begin
            hold_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= NOP_WORD;
            addr_q       <= redir_tgt_d;
            state_q      <= S_REQ;
            req_q        <= 1'b1;
          end else if (!stall) begin
            instr_q      <= hold_instr_q;
            pc4_q        <= hold_pc4_q;
            valid_q      <= hold_valid_q;
            hold_valid_q <= 1'b0;
            addr_q       <= hold_pc4_q;
            state_q      <= S_REQ;
            req_q        <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign Instruccion = instr_q;
  assign if_pc_plus4 = pc4_q;
  assign if_valid    = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by a randomized run,
// every cycle compared with a behavioural model of the fetch stage and its
// instruction memory.
module tb_fetch_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, imem_ack;
  logic [31:0] branch_target, jump_target, imem_data;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, Instruccion, if_pc_plus4;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(RPC), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .Instruccion(Instruccion), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid)
  );

  typedef struct {
    logic [31:0] w;
    logic [31:0] p4;
  } slot_t;

  // Reference model of what the fetch stage should be presenting.
  string       m_phase = "IDLE";
  bit          m_known = 1'b0;
  logic [31:0] m_addr, m_ins, m_pc4, m_ptgt;
  logic        m_val, m_pend;
  slot_t       m_hold[$];

  // Memory side: cycles the current request has waited, and its latency.
  int          wcnt = 0;
  int          lat = 0;
  bit          rand_lat = 1'b0;

  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_req;
    if (m_known) begin
      exp_req = (m_phase == "REQ");
      chk("imem_req",    {31'b0, imem_req}, {31'b0, exp_req});
      chk("imem_addr",   imem_addr,         m_addr);
      chk("Instruccion", Instruccion,       m_ins);
      chk("if_pc_plus4", if_pc_plus4,       m_pc4);
      chk("if_valid",    {31'b0, if_valid}, {31'b0, m_val});
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic br,
                            input logic [31:0] bt, input logic jp,
                            input logic [31:0] jt, input logic ack,
                            input logic [31:0] d);
    logic        redir;
    logic [31:0] tgt;
    slot_t       s;
    if (rst) begin
      m_known = 1'b1;
      m_phase = "IDLE";
      m_addr  = RPC;
      m_ins   = NOP;
      m_pc4   = 32'h0;
      m_val   = 1'b0;
      m_pend  = 1'b0;
      m_ptgt  = 32'h0;
      m_hold.delete();
    end else begin
      redir = jp || br;
      tgt = jp ? jt : bt;
      tgt[1:0] = 2'b00;
      if (m_phase == "IDLE") begin
        if (redir) begin
          m_addr = tgt; m_val = 1'b0; m_ins = NOP;
        end
        m_phase = "REQ";
      end else if (m_phase == "REQ") begin
        if (redir) begin
          m_val = 1'b0; m_ins = NOP;
          if (ack) begin
            m_addr = tgt; m_pend = 1'b0;
          end else begin
            m_pend = 1'b1; m_ptgt = tgt;
          end
        end else if (m_pend) begin
          if (ack) begin
            m_addr = m_ptgt; m_pend = 1'b0;
          end
        end else if (ack && st) begin
          s.w = d; s.p4 = m_addr + 32'd4;
          m_hold.push_back(s);
          m_phase = "HOLD";
        end else if (ack) begin
          m_ins = d; m_pc4 = m_addr + 32'd4; m_val = 1'b1; m_addr = m_addr + 32'd4;
        end else if (!st) begin
          m_val = 1'b0; m_ins = NOP;
        end
      end else begin
        if (redir) begin
          m_hold.delete();
          m_val = 1'b0; m_ins = NOP; m_addr = tgt; m_phase = "REQ";
        end else if (!st) begin
          s = m_hold.pop_front();
          m_ins = s.w; m_pc4 = s.p4; m_val = 1'b1; m_addr = s.p4; m_phase = "REQ";
        end
      end
    end
  endtask

  // One clock: check at the negedge, drive inputs, advance model, wait a cycle.
  task automatic cycle(input logic rst, input logic st, input logic br,
                       input logic [31:0] bt, input logic jp,
                       input logic [31:0] jt, input logic spur);
    logic do_ack;
    logic was_req;
    check_outputs();
    was_req = m_known && (m_phase == "REQ");
    do_ack  = was_req && (wcnt >= lat);
    reset         = rst;
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    imem_ack      = do_ack | (spur & ~was_req);
    imem_data     = do_ack ? mem_word(m_addr) : $urandom();
    model_step(rst, st, br, bt, jp, jt, do_ack, imem_data);
    if (rst) wcnt = 0;
    else if (do_ack) begin
      wcnt = 0;
      if (rand_lat) lat = $urandom_range(0, 2);
    end else if (was_req) wcnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic        r_rst, r_st, r_br, r_jp, r_spur;
    logic [31:0] r_bt, r_jt;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0; imem_ack = 1'b0; imem_data = 32'h0;

    // Reset, then zero-wait memory; a stray ack during IDLE must be ignored.
    lat = 0;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    idle_cycles(4);

    // Stall for 3 cycles while the word at 0x10 comes back.
    chk("pre_stall_addr", imem_addr, 32'h10);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle_cycles(1);
    chk("hold_instr", Instruccion, mem_word(32'h10));
    chk("hold_pc4",   if_pc_plus4, 32'h14);
    chk("hold_resume", imem_addr,  32'h14);

    // Branch to 0x40 while the 0x20 fetch waits two cycles for its ack.
    idle_cycles(3);
    lat = 2;
    cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    idle_cycles(2);
    chk("branch_addr",  imem_addr, 32'h40);
    chk("branch_valid", {31'b0, if_valid}, 32'h0);
    lat = 0;
    idle_cycles(1);
    chk("branch_word", Instruccion, mem_word(32'h40));

    // Two-cycle memory: bubble after every delivered word.
    lat = 1;
    idle_cycles(8);

    // Jump and branch together under stall: jump wins, IF/ID flushed.
    lat = 0;
    cycle(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h100, 1'b0);
    chk("jump_addr",  imem_addr, 32'h100);
    chk("jump_valid", {31'b0, if_valid}, 32'h0);
    chk("jump_instr", Instruccion, NOP);
    idle_cycles(1);

    // Unaligned target near the top of memory, then wrap to zero.
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    chk("align_addr", imem_addr, 32'hFFFF_FFFC);
    idle_cycles(1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4",  if_pc_plus4, 32'h0);

    // Second redirect while one is pending replaces the target.
    lat = 2;
    cycle(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
    idle_cycles(1);
    chk("pend_overwrite", imem_addr, 32'h400);
    lat = 0;
    idle_cycles(2);

    // Reset while in HOLD with a redirect arriving.
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, RPC);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    idle_cycles(1);
    chk("rst_first_addr", imem_addr, RPC);
    chk("rst_first_req",  {31'b0, imem_req}, 32'h1);

    // Randomized traffic with variable latency.
    rand_lat = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      r_rst  = ($urandom_range(0, 199) == 0);
      r_st   = ($urandom_range(0, 9) < 3);
      r_br   = ($urandom_range(0, 99) < 8);
      r_jp   = ($urandom_range(0, 99) < 4);
      r_spur = ($urandom_range(0, 4) == 0);
      r_bt   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      r_jt   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      cycle(r_rst, r_st, r_br, r_bt, r_jp, r_jt, r_spur);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
